// File: rtl/alu_bist_driver_if.sv
// Operand/result bundle between the BIST driver (master) and the ALU under test (slave).
// Purely combinational hand-off: the ALU answers whatever a/b/op currently hold.
interface alu_bist_driver_if;
   logic [31:0] a;
   logic [31:0] b;
   logic [2:0]  op;
   logic [31:0] z;
   logic        ex;

   modport master (output a, b, op, input z, ex);
   modport slave  (input a, b, op, output z, ex);
endinterface

// File: rtl/alu_bist_driver.sv
// In-hardware ALU self-check: LFSR operands, cycling ops, on-chip expected result and pass/fail tally.
// Latency 2+SETTLE cycles per vector; no backpressure, the ALU must settle within SETTLE cycles.
module alu_bist_driver #(
   parameter int unsigned NUM_VECTORS = 16,
   parameter int unsigned SETTLE      = 1,
   parameter logic [31:0] SEED        = 32'hACE1_2468
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   alu_bist_driver_if.master        alu,
   output logic [15:0]              pass_cnt,
   output logic [15:0]              fail_cnt,
   output logic [15:0]              first_fail_idx,
   output logic [2:0]               first_fail_op
);

   // An all-zero state would lock the LFSR up.
   localparam logic [31:0] SEED_EFF    = (SEED == 32'd0) ? 32'd1 : SEED;
   localparam logic [15:0] LAST_IDX    = 16'(NUM_VECTORS - 1);
   localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GEN,
      S_WAIT,
      S_CHECK,
      S_DONE
   } state_t;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  op;
   } vec_t;

   state_t      state_q, state_d;
   vec_t        vec_q;
   logic [31:0] lfsr_q;
   logic [31:0] lfsr_n1, lfsr_n2;
   logic [15:0] idx_q;
   logic [2:0]  phase_q;
   logic [3:0]  wait_q;
   logic [31:0] exp_z;
   logic        exp_ex;
   logic        match;
   logic        accept;

   function automatic logic [31:0] lfsr_nxt(input logic [31:0] s);
      return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
   endfunction

   function automatic logic [2:0] op_of_phase(input logic [2:0] ph);
      case (ph)
         3'd0:    return 3'b000;
         3'd1:    return 3'b001;
         3'd2:    return 3'b010;
         3'd3:    return 3'b110;
         default: return 3'b111;
      endcase
   endfunction

   assign lfsr_n1 = lfsr_nxt(lfsr_q);
   assign lfsr_n2 = lfsr_nxt(lfsr_n1);
   assign accept  = start && ((state_q == S_IDLE) || (state_q == S_DONE));

   assign alu.a  = vec_q.a;
   assign alu.b  = vec_q.b;
   assign alu.op = vec_q.op;

   always_comb begin
      exp_z = 32'd0;
      case (vec_q.op)
         3'b000:  exp_z = vec_q.a & vec_q.b;
         3'b001:  exp_z = vec_q.a | vec_q.b;
         3'b010:  exp_z = vec_q.a + vec_q.b;
         3'b110:  exp_z = vec_q.a - vec_q.b;
         3'b111:  exp_z = {31'd0, $signed(vec_q.a) < $signed(vec_q.b)};
         default: exp_z = 32'd0;
      endcase
   end

   assign exp_ex = (exp_z == 32'd0);
   // An X/Z on z or ex makes match unknown, which lands in the fail branch below.
   assign match  = (alu.z == exp_z) && (alu.ex == exp_ex);

   always_ff @(posedge clk) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: if (start) state_d = (NUM_VECTORS == 0) ? S_DONE : S_GEN;
         S_GEN:          state_d = S_WAIT;
         S_WAIT:         if (wait_q == SETTLE_LAST) state_d = S_CHECK;
         S_CHECK:        state_d = (idx_q == LAST_IDX) ? S_DONE : S_GEN;
         default:        state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_q)
         S_GEN, S_WAIT, S_CHECK: busy = 1'b1;
         S_DONE:                 done = 1'b1;
         default:                ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         vec_q          <= '0;
         lfsr_q         <= SEED_EFF;
         idx_q          <= 16'd0;
         phase_q        <= 3'd0;
         wait_q         <= 4'd0;
         pass_cnt       <= 16'd0;
         fail_cnt       <= 16'd0;
         first_fail_idx <= 16'hFFFF;
         first_fail_op  <= 3'd0;
      end else begin
         if (accept) begin
            lfsr_q         <= SEED_EFF;
            idx_q          <= 16'd0;
            phase_q        <= 3'd0;
            pass_cnt       <= 16'd0;
            fail_cnt       <= 16'd0;
            first_fail_idx <= 16'hFFFF;
            first_fail_op  <= 3'd0;
         end
         if (state_q == S_GEN) begin
            vec_q   <= '{a: lfsr_n1, b: lfsr_n2, op: op_of_phase(phase_q)};
            lfsr_q  <= lfsr_n2;
            phase_q <= (phase_q == 3'd4) ? 3'd0 : phase_q + 3'd1;
            wait_q  <= 4'd0;
         end
         if (state_q == S_WAIT) begin
            wait_q <= wait_q + 4'd1;
         end
         if (state_q == S_CHECK) begin
            if (match) begin
               pass_cnt <= pass_cnt + 16'd1;
            end else begin
               fail_cnt <= fail_cnt + 16'd1;
               if (fail_cnt == 16'd0) begin
                  first_fail_idx <= idx_q;
                  first_fail_op  <= vec_q.op;
               end
            end
            if (idx_q != LAST_IDX) idx_q <= idx_q + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_alu_bist_driver.sv
// Bench for alu_bist_driver: three instances (10/5/0 vectors) against a fault-injectable ALU model.
module tb_alu_bist_driver;

   localparam logic [31:0] SEED = 32'hACE1_2468;
   localparam int MODE_OK   = 0;
   localparam int MODE_INV0 = 1;
   localparam int MODE_SLT0 = 2;
   localparam int MODE_RAND = 3;

   typedef struct packed {
      logic        busy;
      logic        done;
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  op;
      logic [15:0] pass;
      logic [15:0] fail;
      logic [15:0] ffi;
      logic [2:0]  ffo;
   } obs_t;

   typedef struct {
      int          sel;
      int          mode;
      logic [15:0] pass;
      logic [15:0] fail;
      logic [15:0] ffi;
      logic [2:0]  ffo;
   } row_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  start_v;
   logic [2:0]  busy_v, done_v;
   logic [15:0] pass_c [3];
   logic [15:0] fail_c [3];
   logic [15:0] ffi_c  [3];
   logic [2:0]  ffo_c  [3];
   obs_t        o [3];

   int          mode  = MODE_OK;
   logic [1:0]  rkey  = 2'd0;
   logic [31:0] rmask = 32'd1;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] ma [16];
   logic [31:0] mb [16];
   logic [31:0] cap_a [16];
   logic [31:0] cap_b [16];
   logic [2:0]  cap_op [16];

   always #5 clk = ~clk;

   // Spec-level model: LFSR step, op schedule, reference ALU and the faulty ALU seen by the DUT.
   function automatic logic [31:0] nxt(input logic [31:0] s);
      return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
   endfunction

   function automatic logic [2:0] op_at(input int i);
      case (i % 5)
         0:       return 3'b000;
         1:       return 3'b001;
         2:       return 3'b010;
         3:       return 3'b110;
         default: return 3'b111;
      endcase
   endfunction

   function automatic logic [31:0] ref_z(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
      case (op)
         3'b000:  return a & b;
         3'b001:  return a | b;
         3'b010:  return a + b;
         3'b110:  return a - b;
         3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                                             input int md, input logic [1:0] key, input logic [31:0] mask);
      logic [31:0] z;
      z = ref_z(a, b, op);
      case (md)
         MODE_INV0: z = z ^ 32'd1;
         MODE_SLT0: if (op == 3'b111) z = 32'd0;
         MODE_RAND: if (a[1:0] == key) z = z ^ mask;
         default:   ;
      endcase
      return z;
   endfunction

   function automatic int nv_of(input int sel);
      case (sel)
         0:       return 10;
         1:       return 5;
         default: return 0;
      endcase
   endfunction

   function automatic int st_of(input int sel);
      return (sel == 1) ? 3 : 1;
   endfunction

   function automatic void predict(input int sel, input int md, input logic [1:0] key, input logic [31:0] mask,
                                   output row_t r);
      logic [31:0] got;
      r.sel = sel; r.mode = md; r.pass = 16'd0; r.fail = 16'd0; r.ffi = 16'hFFFF; r.ffo = 3'd0;
      for (int i = 0; i < nv_of(sel); i++) begin
         got = alu_model(ma[i], mb[i], op_at(i), md, key, mask);
         if (got == ref_z(ma[i], mb[i], op_at(i))) begin
            r.pass++;
         end else begin
            if (r.fail == 16'd0) begin
               r.ffi = 16'(i);
               r.ffo = op_at(i);
            end
            r.fail++;
         end
      end
   endfunction

   alu_bist_driver_if bus0 ();
   alu_bist_driver_if bus1 ();
   alu_bist_driver_if bus2 ();

   assign bus0.z  = alu_model(bus0.a, bus0.b, bus0.op, mode, rkey, rmask);
   assign bus0.ex = (bus0.z == 32'd0);
   assign bus1.z  = alu_model(bus1.a, bus1.b, bus1.op, mode, rkey, rmask);
   assign bus1.ex = (bus1.z == 32'd0);
   assign bus2.z  = alu_model(bus2.a, bus2.b, bus2.op, mode, rkey, rmask);
   assign bus2.ex = (bus2.z == 32'd0);

   alu_bist_driver #(.NUM_VECTORS(10), .SETTLE(1), .SEED(SEED)) dut0 (
      .clk(clk), .reset_n(reset_n), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
      .alu(bus0.master), .pass_cnt(pass_c[0]), .fail_cnt(fail_c[0]),
      .first_fail_idx(ffi_c[0]), .first_fail_op(ffo_c[0]));

   alu_bist_driver #(.NUM_VECTORS(5), .SETTLE(3), .SEED(SEED)) dut1 (
      .clk(clk), .reset_n(reset_n), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
      .alu(bus1.master), .pass_cnt(pass_c[1]), .fail_cnt(fail_c[1]),
      .first_fail_idx(ffi_c[1]), .first_fail_op(ffo_c[1]));

   alu_bist_driver #(.NUM_VECTORS(0), .SETTLE(1), .SEED(SEED)) dut2 (
      .clk(clk), .reset_n(reset_n), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
      .alu(bus2.master), .pass_cnt(pass_c[2]), .fail_cnt(fail_c[2]),
      .first_fail_idx(ffi_c[2]), .first_fail_op(ffo_c[2]));

   assign o[0] = {busy_v[0], done_v[0], bus0.a, bus0.b, bus0.op, pass_c[0], fail_c[0], ffi_c[0], ffo_c[0]};
   assign o[1] = {busy_v[1], done_v[1], bus1.a, bus1.b, bus1.op, pass_c[1], fail_c[1], ffi_c[1], ffo_c[1]};
   assign o[2] = {busy_v[2], done_v[2], bus2.a, bus2.b, bus2.op, pass_c[2], fail_c[2], ffi_c[2], ffo_c[2]};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_reset(input int sel, input string tag);
      chk({tag, "_busy"}, o[sel].busy, 0);
      chk({tag, "_done"}, o[sel].done, 0);
      chk({tag, "_a"},    o[sel].a, 0);
      chk({tag, "_b"},    o[sel].b, 0);
      chk({tag, "_op"},   o[sel].op, 0);
      chk({tag, "_pass"}, o[sel].pass, 0);
      chk({tag, "_fail"}, o[sel].fail, 0);
      chk({tag, "_ffi"},  o[sel].ffi, 16'hFFFF);
      chk({tag, "_ffo"},  o[sel].ffo, 0);
   endtask

   // Pulses start, follows the run on falling edges (k = full cycles after the start edge),
   // captures each vector's operands and optionally re-pulses start or asserts reset at a given k.
   task automatic run(input int sel, input int repulse_k, input int reset_k, input string tag,
                      output int cycles, output bit aborted);
      int n, per, k;
      bit busy_gap;
      n = nv_of(sel); per = 2 + st_of(sel); aborted = 0; busy_gap = 0;
      @(negedge clk); start_v[sel] = 1'b1;
      @(negedge clk); start_v[sel] = 1'b0;
      k = 0;
      chk({tag, "_busy_after_start"}, o[sel].busy, (n > 0));
      chk({tag, "_cleared_pass"}, o[sel].pass, 0);
      chk({tag, "_cleared_fail"}, o[sel].fail, 0);
      chk({tag, "_cleared_ffi"},  o[sel].ffi, 16'hFFFF);
      while (!o[sel].done && k < 4000) begin
         if (!o[sel].busy) busy_gap = 1;
         if (k % per == 1 && k / per < 16) begin
            cap_a[k / per] = o[sel].a; cap_b[k / per] = o[sel].b; cap_op[k / per] = o[sel].op;
         end
         if (k % per == per - 1 && k / per < 16) begin
            chk({tag, "_hold_a"},  o[sel].a,  cap_a[k / per]);
            chk({tag, "_hold_op"}, o[sel].op, cap_op[k / per]);
         end
         if (k == reset_k) begin
            reset_n = 1'b0;
            @(posedge clk); #1;
            chk_reset(sel, {tag, "_midrun_reset"});
            @(negedge clk); reset_n = 1'b1;
            aborted = 1;
            break;
         end
         start_v[sel] = (k == repulse_k);
         @(negedge clk); k++;
      end
      start_v[sel] = 1'b0;
      cycles = k;
      if (!aborted) begin
         chk({tag, "_done_reached"}, o[sel].done, 1);
         chk({tag, "_busy_continuous"}, busy_gap, 0);
      end
   endtask

   task automatic exec_row(input row_t r, input int repulse_k, input string tag);
      int cycles, n, per;
      bit aborted;
      mode = r.mode;
      n = nv_of(r.sel); per = 2 + st_of(r.sel);
      run(r.sel, repulse_k, -1, tag, cycles, aborted);
      chk({tag, "_cycles"}, cycles, n * per);
      chk({tag, "_pass"}, o[r.sel].pass, r.pass);
      chk({tag, "_fail"}, o[r.sel].fail, r.fail);
      chk({tag, "_ffi"},  o[r.sel].ffi,  r.ffi);
      chk({tag, "_ffo"},  o[r.sel].ffo,  r.ffo);
      chk({tag, "_busy_in_done"}, o[r.sel].busy, 0);
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s_a%0d", tag, i),  cap_a[i],  ma[i]);
         chk($sformatf("%s_b%0d", tag, i),  cap_b[i],  mb[i]);
         chk($sformatf("%s_op%0d", tag, i), cap_op[i], op_at(i));
      end
      repeat (2) @(negedge clk);
      chk({tag, "_done_holds"}, o[r.sel].done, 1);
      chk({tag, "_pass_holds"}, o[r.sel].pass, r.pass);
   endtask

   initial begin
      row_t        tbl [5];
      row_t        r;
      logic [31:0] s;
      bit          slt4;
      int          cyc;
      bit          ab;

      reset_n = 1'b0;
      start_v = 3'b000;
      s = SEED;
      for (int i = 0; i < 16; i++) begin
         s = nxt(s); ma[i] = s;
         s = nxt(s); mb[i] = s;
      end
      slt4 = ($signed(ma[4]) < $signed(mb[4]));

      tbl[0] = '{sel: 0, mode: MODE_OK,   pass: 16'd10, fail: 16'd0,  ffi: 16'hFFFF, ffo: 3'd0};
      tbl[1] = '{sel: 0, mode: MODE_INV0, pass: 16'd0,  fail: 16'd10, ffi: 16'd0,    ffo: 3'd0};
      tbl[2] = '{sel: 1, mode: MODE_SLT0, pass: slt4 ? 16'd4 : 16'd5, fail: slt4 ? 16'd1 : 16'd0,
                 ffi: slt4 ? 16'd4 : 16'hFFFF, ffo: slt4 ? 3'b111 : 3'b000};
      tbl[3] = '{sel: 2, mode: MODE_OK,   pass: 16'd0,  fail: 16'd0,  ffi: 16'hFFFF, ffo: 3'd0};
      tbl[4] = '{sel: 1, mode: MODE_OK,   pass: 16'd5,  fail: 16'd0,  ffi: 16'hFFFF, ffo: 3'd0};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset(0, "por0");
      chk_reset(1, "por1");
      chk_reset(2, "por2");
      reset_n = 1'b1;

      for (int t = 0; t < 5; t++) exec_row(tbl[t], -1, $sformatf("row%0d", t));

      // Reset at cycle 7 of a run, then a fresh run must replay the seed's operand stream.
      mode = MODE_OK;
      run(0, -1, 7, "rst", cyc, ab);
      chk("rst_aborted", ab, 1);
      for (int i = 0; i < 3; i++) chk($sformatf("rst_pre_a%0d", i), cap_a[i], ma[i]);
      exec_row(tbl[0], -1, "after_reset");

      // Start during busy is ignored; start in DONE replays an identical run.
      exec_row(tbl[0], 10, "repulse_busy");
      exec_row(tbl[0], -1, "restart_in_done");

      for (int it = 0; it < 4; it++) begin
         rkey  = 2'($urandom_range(0, 3));
         rmask = $urandom | 32'd1;
         predict(0, MODE_RAND, rkey, rmask, r);
         exec_row(r, -1, $sformatf("rand%0d", it));
      end
      rkey  = 2'($urandom_range(0, 3));
      rmask = $urandom | 32'd1;
      predict(1, MODE_RAND, rkey, rmask, r);
      exec_row(r, -1, "rand_s3");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_bist_driver.md
Name: alu_bist_driver

Overview:
- Sequential initiator for the 32-bit ALU interface (operands a, b, 3-bit op; result z, flag ex).
- Generates pseudo-random operand pairs from an internal LFSR and cycles through the five supported ops.
- Computes the expected result internally, compares it against the ALU response, and accumulates pass/fail statistics.
- Sits beside the ALU as an in-hardware self-check. A start/done handshake lets a controller run it.

Parameters:
- NUM_VECTORS, 16: number of vectors per run (0..65535).
- SETTLE, 1: cycles operands are held before the compare (1..15).
- SEED, 32'hACE1_2468: LFSR seed loaded at reset and at each start. A value of 0 is replaced by 32'h0000_0001.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a run when idle.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  high while in DONE state.
- a  output  32  operand A to the ALU.
- b  output  32  operand B to the ALU.
- op  output  3  ALU op code.
- z  input  32  ALU result.
- ex  input  1  ALU zero flag.
- pass_cnt  output  16  vectors matched.
- fail_cnt  output  16  vectors mismatched.
- first_fail_idx  output  16  index of the first failing vector; 16'hFFFF if none.
- first_fail_op  output  3  op of the first failing vector; 0 if none.

Behaviour:
- One clock, clk. Reset is synchronous and active-low on reset_n. On reset:
  - FSM goes to IDLE; a, b, op, pass_cnt, fail_cnt, first_fail_op go to 0; first_fail_idx goes to 16'hFFFF; busy and done go to 0.
  - LFSR loads SEED.
- Reset overrides everything, including mid-run; partial counts are discarded.
- LFSR: 32-bit Fibonacci, shift left, fb = s[31]^s[21]^s[1]^s[0]. One vector uses nxt(s) for a and nxt(nxt(s)) for b. The LFSR then holds nxt(nxt(s)).
- Op sequence, by vector index mod 5: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- Expected z:
  - AND, OR: bitwise.
  - ADD, SUB: 32-bit two's-complement, carry/borrow discarded.
  - SLT: signed a<b gives 32'd1, otherwise 32'd0.
- Expected ex = (expected z == 0).
- A vector passes iff z === expected z AND ex === expected ex. Any X/Z on z or ex counts as a fail.
- FSM states: IDLE, GEN, WAIT, CHECK, DONE.
  - IDLE: waits for start=1. On start:
    - clear counters; first_fail_idx=FFFF; reload LFSR with SEED; vector index=0.
    - go to GEN, or straight to DONE if NUM_VECTORS==0.
    - busy=1 next cycle.
  - GEN (1 cycle): register a, b, op for the current index; advance LFSR; go to WAIT.
  - WAIT: hold a, b, op for SETTLE cycles, then go to CHECK.
  - CHECK (1 cycle): sample z and ex, compare, increment pass_cnt or fail_cnt.
    - On the first fail, latch first_fail_idx=index and first_fail_op=op.
    - If index==NUM_VECTORS-1, go to DONE; else index++ and go to GEN.
  - DONE: done=1, busy=0. a, b, op and all counters hold.
    - A new start in DONE begins a fresh run, same as from IDLE.
- a, b, op change only in GEN. They are stable through WAIT and CHECK.
- Per-vector latency is 2+SETTLE cycles. A run ends NUM_VECTORS*(2+SETTLE) cycles after the start edge; done rises on the following edge.
- start while busy is ignored. start coincident with reset_n=0: reset wins.
- Counters are 16-bit and cannot overflow, since NUM_VECTORS ≤ 65535.

Test Plan:
- Correct reference ALU, NUM_VECTORS=10, SETTLE=1, start pulse:
  - done rises 30 cycles after start; pass_cnt=10, fail_cnt=0, first_fail_idx=FFFF.
  - op sequence is 0,1,2,6,7,0,1,2,6,7.
  - First vector: a=nxt(SEED), b=nxt(nxt(SEED)).
- ALU model with z[0] inverted, NUM_VECTORS=10:
  - fail_cnt=10, pass_cnt=0, first_fail_idx=0, first_fail_op=000.
- ALU model correct except SLT returning 0 always, NUM_VECTORS=5:
  - fail_cnt equals 1 iff signed vector-4 a<b, else 0.
  - If that vector fails: first_fail_idx=4, first_fail_op=111.
- NUM_VECTORS=0, start pulse: done=1 the next cycle; counters 0; busy never rises.
- Reset mid-run, reset_n=0 at cycle 7:
  - Next edge: all outputs at reset values, state IDLE.
  - A new start reproduces the same a/b sequence as the first run, because the LFSR reloads SEED.
- start re-pulsed during busy and again in DONE:
  - The busy pulse has no effect.
  - The DONE pulse clears counters and repeats an identical run with identical final counts.
